// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART command-frame controller.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4,
        S_EMIT    = 3'd5
    } frame_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_PARITY  = 3'd1,
        ERR_LEN     = 3'd2,
        ERR_CHK     = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_code_t;

    localparam logic [7:0] SOF_BYTE_DEF = 8'hA5;

    // Counter width able to hold the value `ticks` itself.
    function automatic int tmo_width(input int ticks);
        return (ticks < 2) ? 1 : $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte timeout: counts enabled ticks, saturating at the limit.
module uart_frame_timeout
    import uart_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 704
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = tmo_width(TIMEOUT_TICKS);

    logic [W-1:0] cnt_q;

    assign expired_o = (cnt_q == W'(TIMEOUT_TICKS));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  cnt_q <= '0;
        else if (clr_i)               cnt_q <= '0;
        else if (en_i && !expired_o)  cnt_q <= cnt_q + W'(1);
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frames the uart_rx byte stream (SOF, ADDR, LEN, payload, CHK) and replays
// checksum-verified payloads as register-write beats.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         ADDR_W        = 8,
    parameter int         MAX_LEN       = 16,
    parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEF,
    parameter int         TIMEOUT_TICKS = 704
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tick_i,
    input  logic [7:0]        rx_byte_i,
    input  logic              rx_vld_i,
    input  logic              rx_err_i,
    output logic              wr_vld_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    input  logic              wr_rdy_i,
    output logic              frame_ok_o,
    output logic              frame_err_o,
    output logic [2:0]        err_code_o,
    output logic [7:0]        drop_cnt_o,
    output logic              busy_o,
    output logic [2:0]        fsm_state_o
);

    localparam int         CNT_W     = $clog2(MAX_LEN + 1);
    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]  len_q, len_d, idx_q, idx_d, idx_nxt;
    logic [7:0]        chk_q, chk_d, wr_data_q, wr_data_d, drop_q, drop_d;
    logic              wr_vld_q, wr_vld_d, ok_q, ok_d, ferr_q, ferr_d, busy_q;
    err_code_t         err_q, err_d;
    logic              buf_we, tmo_expired, in_frame;
    logic [7:0]        buf_q [MAX_LEN];

    assign idx_nxt  = idx_q + CNT_W'(1);
    assign in_frame = (state_q != S_IDLE) && (state_q != S_EMIT);

    // Counter restarts on each accepted byte and is frozen while emitting.
    uart_frame_timeout #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_tmo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     ((rx_vld_i && state_q != S_EMIT) || state_q == S_IDLE),
        .en_i      (tick_i && in_frame),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        wr_vld_d  = wr_vld_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        drop_d    = drop_q;
        err_d     = err_q;
        ok_d      = 1'b0;
        ferr_d    = 1'b0;
        buf_we    = 1'b0;
        case (state_q)
            S_IDLE: if (rx_vld_i && rx_byte_i == SOF_BYTE) state_d = S_ADDR;
            S_EMIT: begin
                if (rx_vld_i && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                if (wr_vld_q && wr_rdy_i) begin
                    if (idx_nxt == len_q) begin
                        wr_vld_d = 1'b0;
                        ok_d     = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        idx_d     = idx_nxt;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        wr_data_d = buf_q[idx_nxt[IDX_W-1:0]];
                    end
                end
            end
            default: begin
                // A byte beats a same-cycle timeout; a parity error aborts the frame.
                if (rx_vld_i) begin
                    case (state_q)
                        S_ADDR: begin
                            addr_d  = ADDR_W'(rx_byte_i);
                            chk_d   = rx_byte_i;
                            state_d = S_LEN;
                        end
                        S_LEN: begin
                            if (rx_byte_i == 8'd0 || rx_byte_i > MAX_LEN_B) begin
                                err_d   = ERR_LEN;
                                ferr_d  = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                len_d   = CNT_W'(rx_byte_i);
                                idx_d   = '0;
                                chk_d   = chk_q ^ rx_byte_i;
                                state_d = S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            buf_we = 1'b1;
                            chk_d  = chk_q ^ rx_byte_i;
                            idx_d  = idx_nxt;
                            if (idx_nxt == len_q) state_d = S_CHK;
                        end
                        S_CHK: begin
                            if (rx_byte_i == chk_q) begin
                                state_d   = S_EMIT;
                                idx_d     = '0;
                                wr_vld_d  = 1'b1;
                                wr_addr_d = addr_q;
                                wr_data_d = buf_q[0];
                            end else begin
                                err_d   = ERR_CHK;
                                ferr_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                        default: ;
                    endcase
                end else if (rx_err_i) begin
                    err_d   = ERR_PARITY;
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_expired) begin
                    err_d   = ERR_TIMEOUT;
                    ferr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            drop_q    <= '0;
            err_q     <= ERR_NONE;
            ok_q      <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
            ok_q      <= ok_d;
            ferr_q    <= ferr_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    // Payload storage needs no reset; it is always rewritten before use.
    always_ff @(posedge clk_i) begin
        if (buf_we) buf_q[idx_q[IDX_W-1:0]] <= rx_byte_i;
    end

    assign wr_vld_o    = wr_vld_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign frame_ok_o  = ok_q;
    assign frame_err_o = ferr_q;
    assign err_code_o  = err_q;
    assign drop_cnt_o  = drop_q;
    assign busy_o      = busy_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed stimulus with a scoreboard: expected writes/errors are queued by
// the stimulus and consumed by an independent negedge monitor.
module tb_uart_frame_ctrl;

    logic       clk, rst_n, tick, rx_vld, rx_err, wr_rdy;
    logic [7:0] rx_byte;
    logic       wr_vld_o, frame_ok_o, frame_err_o, busy_o;
    logic [7:0] wr_addr_o, wr_data_o, drop_cnt_o;
    logic [2:0] err_code_o, fsm_state_o;

    uart_frame_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick),
        .rx_byte_i(rx_byte), .rx_vld_i(rx_vld), .rx_err_i(rx_err),
        .wr_vld_o(wr_vld_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .wr_rdy_i(wr_rdy), .frame_ok_o(frame_ok_o), .frame_err_o(frame_err_o),
        .err_code_o(err_code_o), .drop_cnt_o(drop_cnt_o), .busy_o(busy_o),
        .fsm_state_o(fsm_state_o)
    );

    int checks = 0, errors = 0;
    logic [15:0] exp_wq [$];
    logic [2:0]  exp_eq [$];
    int exp_ok = 0, got_ok = 0;
    bit rdy_block = 0, stall_en = 0;
    int stall_left = 0, beat_no = 0;
    bit prev_hold = 0;
    logic [7:0] prev_addr, prev_data;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // One tick every 4 clocks.
    initial begin
        int tc;
        tc = 0;
        tick = 0;
        forever begin
            @(posedge clk); #1;
            tick = (tc == 3);
            tc = (tc + 1) % 4;
        end
    end

    // Monitor and ready driver: rdy set here is what the DUT samples next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
            beat_no = 0;
            wr_rdy = 1;
        end else begin
            if (prev_hold) begin
                check("hold_vld", wr_vld_o, 1);
                check("hold_addr", wr_addr_o, prev_addr);
                check("hold_data", wr_data_o, prev_data);
            end
            if (rdy_block) wr_rdy = 0;
            else if (wr_vld_o && stall_en && beat_no == 1 && stall_left > 0) begin
                wr_rdy = 0;
                stall_left--;
            end else wr_rdy = 1;
            if (wr_vld_o && wr_rdy) begin
                if (exp_wq.size() == 0) check("unexpected_write", {wr_addr_o, wr_data_o}, 16'hxxxx);
                else begin
                    logic [15:0] e;
                    e = exp_wq.pop_front();
                    check("wr_addr", wr_addr_o, e[15:8]);
                    check("wr_data", wr_data_o, e[7:0]);
                end
                beat_no++;
            end
            prev_hold = wr_vld_o && !wr_rdy;
            prev_addr = wr_addr_o;
            prev_data = wr_data_o;
            if (frame_ok_o) begin
                got_ok++;
                beat_no = 0;
            end
            if (frame_err_o) begin
                if (exp_eq.size() == 0) check("unexpected_err", err_code_o, 3'bxxx);
                else check("err_code", err_code_o, exp_eq.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte = b; rx_vld = 1;
        @(posedge clk); #1;
        rx_vld = 0;
    endtask

    task automatic send_err();
        @(posedge clk); #1;
        rx_err = 1;
        @(posedge clk); #1;
        rx_err = 0;
    endtask

    task automatic frame(input logic [7:0] a, input int n, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [7:0] d2,
                         input logic [7:0] ck, input bit push);
        logic [7:0] pl [3];
        pl[0] = d0; pl[1] = d1; pl[2] = d2;
        if (push) begin
            for (int k = 0; k < n; k++) exp_wq.push_back({a + 8'(k), pl[k]});
            exp_ok++;
        end
        send_byte(8'hA5);
        send_byte(a);
        send_byte(8'(n));
        for (int k = 0; k < n; k++) send_byte(pl[k]);
        send_byte(ck);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int c;
        c = 0;
        do begin
            @(negedge clk); #1;
            c++;
        end while (!(!busy_o && exp_wq.size() == 0 && exp_eq.size() == 0 && got_ok == exp_ok)
                   && c < budget);
        check({nm, "_done"}, (c < budget), 1);
    endtask

    task automatic wait_vld(input string nm);
        int c;
        c = 0;
        while (!wr_vld_o && c < 50) begin
            @(negedge clk);
            c++;
        end
        check({nm, "_vld_seen"}, wr_vld_o, 1);
    endtask

    task automatic reset_checks(input string nm);
        check({nm, "_wr_vld"}, wr_vld_o, 0);
        check({nm, "_wr_addr"}, wr_addr_o, 0);
        check({nm, "_wr_data"}, wr_data_o, 0);
        check({nm, "_ok"}, frame_ok_o, 0);
        check({nm, "_ferr"}, frame_err_o, 0);
        check({nm, "_code"}, err_code_o, 0);
        check({nm, "_drop"}, drop_cnt_o, 0);
        check({nm, "_busy"}, busy_o, 0);
        check({nm, "_state"}, fsm_state_o, 0);
    endtask

    initial begin
        rst_n = 0; rx_vld = 0; rx_err = 0; rx_byte = 0; wr_rdy = 1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1;

        // 1: good frame
        frame(8'h10, 3, 8'h11, 8'h22, 8'h33, 8'h13, 1);
        wait_done(200, "t1");
        check("t1_code", err_code_o, 0);

        // 2: backpressure on beat 2
        stall_en = 1; stall_left = 5;
        frame(8'h10, 3, 8'h11, 8'h22, 8'h33, 8'h13, 1);
        wait_done(200, "t2");
        check("t2_stall_used", stall_left, 0);
        stall_en = 0;

        // 3: bad checksum
        exp_eq.push_back(3'd3);
        frame(8'h10, 3, 8'h11, 8'h22, 8'h33, 8'h14, 0);
        wait_done(200, "t3");

        // 4: LEN zero and LEN too big
        exp_eq.push_back(3'd2);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h00);
        wait_done(200, "t4a");
        exp_eq.push_back(3'd2);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h11);
        wait_done(200, "t4b");
        check("t4_state", fsm_state_o, 0);

        // 5: parity abort, timeout abort, then recovery
        exp_eq.push_back(3'd1);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22);
        send_err();
        wait_done(200, "t5a");
        exp_eq.push_back(3'd4);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
        wait_done(4000, "t5b");
        frame(8'h10, 3, 8'h11, 8'h22, 8'h33, 8'h13, 1);
        wait_done(200, "t5c");

        // 6: address wrap, bytes (including an SOF) dropped during EMIT
        rdy_block = 1;
        frame(8'hFF, 2, 8'hAA, 8'hBB, 8'h00, 8'hEC, 1);
        wait_vld("t6");
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        rdy_block = 0;
        wait_done(200, "t6");
        check("t6_drop", drop_cnt_o, 3);

        // 7: asynchronous reset in EMIT, then a clean frame
        rdy_block = 1;
        frame(8'h10, 3, 8'h11, 8'h22, 8'h33, 8'h13, 0);
        wait_vld("t7");
        #2;
        rst_n = 0;
        #1;
        reset_checks("t7_rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        rdy_block = 0;
        frame(8'h10, 3, 8'h11, 8'h22, 8'h33, 8'h13, 1);
        wait_done(200, "t7");

        check("final_wq_empty", exp_wq.size(), 0);
        check("final_eq_empty", exp_eq.size(), 0);
        check("final_ok_count", got_ok, exp_ok);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
